mem_port_arbiter: RTL

Sequencer and arbiter sharing a single-ported SRAM interface between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. Grants one requester at a time, holds the SRAM transaction until the memory acknowledges, returns read data through registered response ports, and raises per-stage stall requests for the pipeline stall controller. Round-robin fairness applies when both requesters contend; a watchdog terminates hung transactions.

---
 rtl/mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported SRAM between the instruction-fetch requester
// (IF stage) and the data requester (MEM stage).  One requester owns the SRAM
// at a time.  The grant is held until the SRAM acknowledges with mem_ready,
// or until a watchdog gives up on it.  Read data comes back through
// registered response ports, framed by a one-cycle done pulse.  When both
// requesters contend, the grant alternates between them (round robin).
//
// Ports
//   clk, rst            pipeline clock; asynchronous active-high reset
//   inst_req/addr       IF read request, held until inst_done
//   inst_done/rdata     one-cycle completion pulse plus registered word
//   data_req/wen/addr/wdata
//                       MEM request (wen == 4'b0000 means read), held
//                       until data_done
//   data_done/rdata     one-cycle completion pulse plus registered load data
//   mem_en/wen/addr/wdata
//                       SRAM request, driven only while a grant is active
//   mem_rdata/ready     SRAM read data and the one-cycle acknowledge
//   stallreq_if/mem     per-stage hold requests to the stall controller
//   bus_err             sticky flag: a transaction was ended by the watchdog
//
// Parameter
//   TIMEOUT             the maximum number of cycles a grant waits for
//                       mem_ready before the watchdog ends it (>= 2)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_done,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  // The watchdog fires on the grant cycle where the counter holds this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_INST = 2'd1,
    ST_GNT_DATA = 2'd2
  } state_t;

  typedef enum logic {
    LG_INST = 1'b0,
    LG_DATA = 1'b1
  } grant_t;

  state_t            state_r;
  state_t            state_s;
  grant_t            last_grant_r;
  grant_t            last_grant_s;
  logic [CNT_W-1:0]  wd_cnt_r;
  logic [CNT_W-1:0]  wd_cnt_s;

  logic              inst_done_r;
  logic              data_done_r;
  logic [31:0]       inst_rdata_r;
  logic [31:0]       data_rdata_r;
  logic              bus_err_r;

  logic              inst_elig_s;
  logic              data_elig_s;
  logic              in_gnt_s;
  logic              wd_expire_s;
  logic              finish_s;
  logic [31:0]       cap_rdata_s;

  logic              mem_en_s;
  logic [3:0]        mem_wen_s;
  logic [31:0]       mem_addr_s;
  logic [31:0]       mem_wdata_s;

  // A requester is not eligible in the cycle in which its done pulse is
  // visible.  It may still hold req with the next request, and this rule
  // stops that request from being mistaken for the one just completed.
  assign inst_elig_s = inst_req & ~inst_done_r;
  assign data_elig_s = data_req & ~data_done_r;

  assign in_gnt_s    = (state_r == ST_GNT_INST) || (state_r == ST_GNT_DATA);
  // If mem_ready arrives on the last allowed cycle, the transaction ends
  // normally and the watchdog does not fire.
  assign wd_expire_s = in_gnt_s & ~mem_ready & (wd_cnt_r == CNT_LAST);
  assign finish_s    = in_gnt_s & (mem_ready | wd_expire_s);
  // Writes, and transactions ended by the watchdog, return zero data.
  assign cap_rdata_s = (mem_ready && (mem_wen_s == 4'b0000)) ? mem_rdata : 32'h0000_0000;

  // Next-state, round-robin arbitration and watchdog counter update
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    wd_cnt_s     = wd_cnt_r;
    case (state_r)
      ST_IDLE: begin
        wd_cnt_s = CNT_ZERO;
        if (inst_elig_s && data_elig_s) begin
          // Contention: the side that did not win last time gets the grant.
          if (last_grant_r == LG_INST) begin
            state_s      = ST_GNT_DATA;
            last_grant_s = LG_DATA;
          end else begin
            state_s      = ST_GNT_INST;
            last_grant_s = LG_INST;
          end
        end else if (inst_elig_s) begin
          state_s      = ST_GNT_INST;
          last_grant_s = LG_INST;
        end else if (data_elig_s) begin
          state_s      = ST_GNT_DATA;
          last_grant_s = LG_DATA;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GNT_INST, ST_GNT_DATA: begin
        if (finish_s) begin
          state_s  = ST_IDLE;
          wd_cnt_s = CNT_ZERO;
        end else begin
          wd_cnt_s = wd_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        last_grant_s = LG_INST;
        wd_cnt_s     = CNT_ZERO;
      end
    endcase
  end

  // State, last-grant and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= LG_INST;
      wd_cnt_r     <= CNT_ZERO;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      wd_cnt_r     <= wd_cnt_s;
    end
  end

  // SRAM bus decode: the owning requester's fields while granted, zero otherwise
  always_comb begin
    mem_en_s    = 1'b0;
    mem_wen_s   = 4'b0000;
    mem_addr_s  = 32'h0000_0000;
    mem_wdata_s = 32'h0000_0000;
    case (state_r)
      ST_GNT_INST: begin
        mem_en_s   = 1'b1;
        mem_addr_s = inst_addr;
      end
      ST_GNT_DATA: begin
        mem_en_s    = 1'b1;
        mem_wen_s   = data_wen;
        mem_addr_s  = data_addr;
        mem_wdata_s = data_wdata;
      end
      default: begin
        mem_en_s = 1'b0;
      end
    endcase
  end

  // Completion pulses, response data capture and the sticky bus error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_done_r  <= 1'b0;
      data_done_r  <= 1'b0;
      inst_rdata_r <= 32'h0000_0000;
      data_rdata_r <= 32'h0000_0000;
      bus_err_r    <= 1'b0;
    end else begin
      inst_done_r <= finish_s && (state_r == ST_GNT_INST);
      data_done_r <= finish_s && (state_r == ST_GNT_DATA);
      if (finish_s && (state_r == ST_GNT_INST)) begin
        inst_rdata_r <= cap_rdata_s;
      end
      if (finish_s && (state_r == ST_GNT_DATA)) begin
        data_rdata_r <= cap_rdata_s;
      end
      if (wd_expire_s) begin
        bus_err_r <= 1'b1;
      end
    end
  end

  assign mem_en       = mem_en_s;
  assign mem_wen      = mem_wen_s;
  assign mem_addr     = mem_addr_s;
  assign mem_wdata    = mem_wdata_s;

  assign inst_done    = inst_done_r;
  assign data_done    = data_done_r;
  assign inst_rdata   = inst_rdata_r;
  assign data_rdata   = data_rdata_r;
  assign bus_err      = bus_err_r;

  // The stall controller needs the hold request in the same cycle as req.
  assign stallreq_if  = inst_req & ~inst_done_r;
  assign stallreq_mem = data_req & ~data_done_r;

endmodule
